// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the memory port arbiter.
package mem_arb_pkg;
  localparam int MEM_ADDR_W = 64;
  localparam int MEM_DATA_W = 64;
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;
  typedef enum logic {OWN_IF, OWN_LS} owner_e;
  typedef struct packed {
    logic [MEM_ADDR_W-1:0]   addr;
    logic                    we;
    logic [MEM_DATA_W-1:0]   wdata;
    logic [MEM_DATA_W/8-1:0] wstrb;
  } req_t;
endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select: IF/LS winner selection; MEM_ARB_RR_EN swaps fixed priority plus
// starvation guard for round-robin on the last winner.
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_i,
  input  logic if_valid_i,
  input  logic ls_valid_i,
  output logic if_win_o,
  output logic ls_win_o
);
`ifdef MEM_ARB_RR_EN
  owner_e last_q, last_d;
  always_comb begin
    if_win_o = if_valid_i && (!ls_valid_i || last_q == OWN_LS);
    ls_win_o = ls_valid_i && !if_win_o;
    last_d = (arb_i && if_win_o) ? OWN_IF : (arb_i && ls_win_o) ? OWN_LS : last_q;
  end
  always_ff @(posedge clk) begin
    if (rst) last_q <= OWN_LS;
    else last_q <= last_d;
  end
`else
  logic [3:0] starve_q, starve_d;
  // IF always wins at the limit, so the count can never pass it
  always_comb begin
    if_win_o = if_valid_i && (!ls_valid_i || starve_q == 4'(STARVE_LIMIT));
    ls_win_o = ls_valid_i && !if_win_o;
    starve_d = !arb_i ? starve_q : (if_valid_i && !if_win_o) ? starve_q + 4'd1 : 4'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) starve_q <= 4'd0;
    else starve_q <= starve_d;
  end
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF and LS, one transaction in flight.
// Build option MEM_ARB_RR_EN selects round-robin arbitration.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = MEM_ADDR_W,
  parameter int DATA_W       = MEM_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_inst,
  input  logic              ls_req_valid,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic              ls_req_we,
  input  logic [DATA_W-1:0] ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wstrb,
  output logic              ls_req_ready,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_e state_q, state_d;
  owner_e owner_q;
  req_t   req_q;
  logic   if_win, ls_win, done;

  mem_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
    .clk        (clk),
    .rst        (rst),
    .arb_i      (state_q == IDLE),
    .if_valid_i (if_req_valid),
    .ls_valid_i (ls_req_valid),
    .if_win_o   (if_win),
    .ls_win_o   (ls_win)
  );

  always_comb begin
    state_d = state_q == IDLE ? ((if_win || ls_win) ? REQ : IDLE)
            : state_q == REQ  ? (mem_gnt ? RSP : REQ)
            : (state_q == RSP && !mem_rvalid) ? RSP : IDLE;
    if_req_ready = state_q == IDLE && if_win;
    ls_req_ready = state_q == IDLE && ls_win;
    done = state_q == RSP && mem_rvalid;
    mem_req = state_q == REQ;
    mem_addr = req_q.addr;
    mem_we = req_q.we;
    mem_wdata = req_q.wdata;
    mem_wstrb = req_q.wstrb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      req_q <= '0;
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      if_rsp_inst <= '0;
      ls_rsp_rdata <= '0;
    end else begin
      state_q <= state_d;
      if (ls_req_ready) begin
        owner_q <= OWN_LS;
        req_q.addr <= ls_req_addr;
        req_q.we <= ls_req_we;
        req_q.wdata <= ls_req_wdata;
        req_q.wstrb <= ls_req_wstrb;
      end else if (if_req_ready) begin
        owner_q <= OWN_IF;
        req_q.addr <= if_req_addr;
        req_q.we <= 1'b0;
        req_q.wdata <= '0;
        req_q.wstrb <= '0;
      end
      if_rsp_valid <= done && owner_q == OWN_IF;
      ls_rsp_valid <= done && owner_q == OWN_LS;
      if (done && owner_q == OWN_IF) if_rsp_inst <= req_q.addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
      if (done && owner_q == OWN_LS) ls_rsp_rdata <= req_q.we ? '0 : mem_rdata;
    end
  end
endmodule
